// File: rtl/mem_store_buffer_if.sv
// rtl/mem_store_buffer_if.sv - pipeline and Data_Memory port bundle for the store buffer
interface mem_store_buffer_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 3
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_stall;
  logic              drain_req;
  logic              drained;
  logic [CNT_W-1:0]  occupancy;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_memwrite;
  logic              dm_memread;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, drain_req, dm_rdata,
    input  st_ready, ld_data, ld_stall, drained, occupancy,
    input  dm_addr, dm_wdata, dm_memwrite, dm_memread
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, drain_req, dm_rdata,
    output st_ready, ld_data, ld_stall, drained, occupancy,
    output dm_addr, dm_wdata, dm_memwrite, dm_memread
  );
endinterface

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - store FIFO between EX/MEM and Data_Memory with load forwarding
module mem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 3
) (
  input logic clk,
  input logic reset,
  mem_store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              partial_hit, exact_hit;
  logic [31:0]       fwd_data;
  logic [PTR_W-1:0]  idx;
  logic [ADDR_W-1:0] diff;
  logic              conflict, mem_read, push, pop;
  logic              unused_hi;

  assign unused_hi = ^bus.st_data[DATA_W-1:32];

  // Walk oldest to youngest so the last exact match is the youngest store.
  always_comb begin
    partial_hit = 1'b0;
    exact_hit   = 1'b0;
    fwd_data    = '0;
    idx         = '0;
    diff        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx  = head_q + PTR_W'(k);
      diff = addr_q[idx] - bus.ld_addr;
      if (valid_q[idx]) begin
        if (addr_q[idx] == bus.ld_addr) begin
          exact_hit = 1'b1;
          fwd_data  = data_q[idx];
        end else if ((diff < ADDR_W'(4)) || (diff > ({ADDR_W{1'b1}} - ADDR_W'(3)))) begin
          partial_hit = 1'b1;
        end
      end
    end
  end

  // A store colliding with a load keeps the port idle: the stalled load still owns it.
  assign conflict = bus.st_valid && bus.ld_valid;
  assign bus.ld_stall = bus.ld_valid && (conflict || partial_hit);
  assign mem_read = bus.ld_valid && !bus.ld_stall && !exact_hit;
  assign pop = !mem_read && !conflict && (count_q != '0);
  assign bus.st_ready = (count_q < CNT_W'(DEPTH)) && !bus.drain_req;
  assign push = bus.st_valid && bus.st_ready;

  assign bus.drained   = (count_q == '0);
  assign bus.occupancy = count_q;

  always_comb begin
    bus.dm_memread  = 1'b0;
    bus.dm_memwrite = 1'b0;
    bus.dm_addr     = '0;
    bus.dm_wdata    = '0;
    bus.ld_data     = '0;
    if (mem_read) begin
      bus.dm_memread = 1'b1;
      bus.dm_addr    = bus.ld_addr;
      bus.ld_data    = bus.dm_rdata;
    end else begin
      if (bus.ld_valid && !bus.ld_stall) begin
        bus.ld_data = {{(DATA_W-32){1'b0}}, fwd_data};
      end
      if (pop) begin
        bus.dm_memwrite = 1'b1;
        bus.dm_addr     = addr_q[head_q];
        bus.dm_wdata    = {{(DATA_W-32){1'b0}}, data_q[head_q]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data[31:0];
    end
  end
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb/tb_mem_store_buffer.sv - directed self-checking bench for mem_store_buffer
module tb_mem_store_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_store_buffer_if #(.ADDR_W(64), .DATA_W(64), .CNT_W(3)) bus();
  mem_store_buffer #(.DEPTH(4), .ADDR_W(64), .DATA_W(64), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem [256];
  int n_writes = 0;
  int base;

  assign bus.dm_rdata = {32'h0, mem[bus.dm_addr[7:0]]};

  // Byte-indexed word memory, preset to 0xD000+addr while reset is held.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hD000 + i;
    end else if (bus.dm_memwrite) begin
      mem[bus.dm_addr[7:0]] <= bus.dm_wdata[31:0];
      n_writes <= n_writes + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.st_valid = 0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_valid = 0; bus.ld_addr = '0; bus.drain_req = 0;
  endtask

  task automatic store_with_load(input logic [63:0] a, input logic [63:0] d);
    tick;
    bus.st_valid = 1; bus.st_addr = a; bus.st_data = d;
    bus.ld_valid = 1; bus.ld_addr = 64'd100;
  endtask

  task automatic test_reset;
    reset = 1; idle;
    tick; tick; #1;
    n_cmp++; if (bus.st_ready !== 1'b1) begin n_bad++; $display("FAIL reset_st_ready got %0h want 1", bus.st_ready); end
    n_cmp++; if (bus.drained !== 1'b1) begin n_bad++; $display("FAIL reset_drained got %0h want 1", bus.drained); end
    n_cmp++; if (bus.occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.dm_memwrite !== 1'b0) begin n_bad++; $display("FAIL reset_memwrite got %0h want 0", bus.dm_memwrite); end
    n_cmp++; if (bus.dm_memread !== 1'b0) begin n_bad++; $display("FAIL reset_memread got %0h want 0", bus.dm_memread); end
    n_cmp++; if (bus.ld_stall !== 1'b0) begin n_bad++; $display("FAIL reset_ld_stall got %0h want 0", bus.ld_stall); end
    n_cmp++; if (bus.ld_data !== 64'h0) begin n_bad++; $display("FAIL reset_ld_data got %0h want 0", bus.ld_data); end
    tick; reset = 0;
  endtask

  task automatic test_drain_order;
    base = n_writes;
    tick; bus.st_valid = 1; bus.st_addr = 64'd8; bus.st_data = 64'hA; #1;
    n_cmp++; if (bus.st_ready !== 1'b1) begin n_bad++; $display("FAIL drain_st_ready got %0h want 1", bus.st_ready); end
    n_cmp++; if (bus.dm_memwrite !== 1'b0) begin n_bad++; $display("FAIL drain_c0_memwrite got %0h want 0", bus.dm_memwrite); end
    tick; bus.st_addr = 64'd16; bus.st_data = 64'hB; #1;
    n_cmp++; if (bus.dm_memwrite !== 1'b1 || bus.dm_addr !== 64'd8 || bus.dm_wdata !== 64'hA) begin n_bad++; $display("FAIL drain_c1 got we=%0h a=%0d d=%0h want 1/8/a", bus.dm_memwrite, bus.dm_addr, bus.dm_wdata); end
    tick; bus.st_addr = 64'd24; bus.st_data = 64'hC; #1;
    n_cmp++; if (bus.dm_memwrite !== 1'b1 || bus.dm_addr !== 64'd16) begin n_bad++; $display("FAIL drain_c2 got we=%0h a=%0d want 1/16", bus.dm_memwrite, bus.dm_addr); end
    tick; idle; #1;
    n_cmp++; if (bus.dm_memwrite !== 1'b1 || bus.dm_addr !== 64'd24 || bus.occupancy !== 3'd1) begin n_bad++; $display("FAIL drain_c3 got we=%0h a=%0d occ=%0d want 1/24/1", bus.dm_memwrite, bus.dm_addr, bus.occupancy); end
    tick; #1;
    n_cmp++; if (bus.drained !== 1'b1 || bus.dm_memwrite !== 1'b0) begin n_bad++; $display("FAIL drain_done got drained=%0h we=%0h want 1/0", bus.drained, bus.dm_memwrite); end
    n_cmp++; if (mem[8] !== 32'hA || mem[16] !== 32'hB || mem[24] !== 32'hC) begin n_bad++; $display("FAIL drain_mem got %0h %0h %0h want a b c", mem[8], mem[16], mem[24]); end
    n_cmp++; if (n_writes - base !== 3) begin n_bad++; $display("FAIL drain_write_count got %0d want 3", n_writes - base); end
  endtask

  task automatic test_full;
    base = n_writes;
    for (int i = 0; i < 4; i++) begin
      store_with_load(64'd200 + 64'(4 * i), 64'(i + 1)); #1;
      n_cmp++; if (bus.st_ready !== 1'b1 || bus.ld_stall !== 1'b1 || bus.dm_memwrite !== 1'b0 || bus.dm_memread !== 1'b0) begin n_bad++; $display("FAIL full_push%0d got rdy=%0h stall=%0h we=%0h re=%0h want 1/1/0/0", i, bus.st_ready, bus.ld_stall, bus.dm_memwrite, bus.dm_memread); end
    end
    store_with_load(64'd216, 64'd5); #1;
    n_cmp++; if (bus.st_ready !== 1'b0 || bus.occupancy !== 3'd4) begin n_bad++; $display("FAIL full_fifth got rdy=%0h occ=%0d want 0/4", bus.st_ready, bus.occupancy); end
    tick; bus.st_valid = 0; #1;
    n_cmp++; if (bus.dm_memread !== 1'b1 || bus.ld_data !== 64'hD064 || bus.ld_stall !== 1'b0 || bus.dm_memwrite !== 1'b0) begin n_bad++; $display("FAIL full_load got re=%0h data=%0h stall=%0h we=%0h want 1/d064/0/0", bus.dm_memread, bus.ld_data, bus.ld_stall, bus.dm_memwrite); end
    tick; idle; #1;
    n_cmp++; if (bus.dm_memwrite !== 1'b1 || bus.dm_addr !== 64'd200 || bus.st_ready !== 1'b0) begin n_bad++; $display("FAIL full_pop1 got we=%0h a=%0d rdy=%0h want 1/200/0", bus.dm_memwrite, bus.dm_addr, bus.st_ready); end
    tick; #1;
    n_cmp++; if (bus.occupancy !== 3'd3 || bus.st_ready !== 1'b1 || bus.dm_addr !== 64'd204) begin n_bad++; $display("FAIL full_pop2 got occ=%0d rdy=%0h a=%0d want 3/1/204", bus.occupancy, bus.st_ready, bus.dm_addr); end
    for (int c = 0; c < 10 && !bus.drained; c++) tick;
    n_cmp++; if (bus.drained !== 1'b1) begin n_bad++; $display("FAIL full_drain_timeout got drained=%0h want 1", bus.drained); end
    n_cmp++; if (mem[200] !== 32'd1 || mem[204] !== 32'd2 || mem[208] !== 32'd3 || mem[212] !== 32'd4 || mem[216] !== 32'hD0D8) begin n_bad++; $display("FAIL full_mem got %0h %0h %0h %0h %0h want 1 2 3 4 d0d8", mem[200], mem[204], mem[208], mem[212], mem[216]); end
    n_cmp++; if (n_writes - base !== 4) begin n_bad++; $display("FAIL full_write_count got %0d want 4", n_writes - base); end
  endtask

  task automatic test_forward;
    store_with_load(64'd16, 64'h11);
    store_with_load(64'd16, 64'h22);
    tick; bus.st_valid = 0; bus.ld_addr = 64'd16; #1;
    n_cmp++; if (bus.ld_data !== 64'h22 || bus.ld_stall !== 1'b0 || bus.dm_memread !== 1'b0) begin n_bad++; $display("FAIL fwd_youngest got data=%0h stall=%0h re=%0h want 22/0/0", bus.ld_data, bus.ld_stall, bus.dm_memread); end
    n_cmp++; if (bus.dm_memwrite !== 1'b1 || bus.dm_addr !== 64'd16 || bus.dm_wdata !== 64'h11) begin n_bad++; $display("FAIL fwd_drain got we=%0h a=%0d d=%0h want 1/16/11", bus.dm_memwrite, bus.dm_addr, bus.dm_wdata); end
    tick; #1;
    n_cmp++; if (bus.ld_data !== 64'h22 || bus.dm_memwrite !== 1'b1 || bus.dm_wdata !== 64'h22) begin n_bad++; $display("FAIL fwd_last got data=%0h we=%0h d=%0h want 22/1/22", bus.ld_data, bus.dm_memwrite, bus.dm_wdata); end
    tick; #1;
    n_cmp++; if (bus.dm_memread !== 1'b1 || bus.ld_data !== 64'h22) begin n_bad++; $display("FAIL fwd_from_mem got re=%0h data=%0h want 1/22", bus.dm_memread, bus.ld_data); end
    tick; idle;
  endtask

  task automatic test_partial;
    store_with_load(64'd16, 64'h33);
    store_with_load(64'd20, 64'h44);
    tick; bus.st_valid = 0; bus.ld_addr = 64'd18; #1;
    n_cmp++; if (bus.ld_stall !== 1'b1 || bus.ld_data !== 64'h0 || bus.dm_memread !== 1'b0 || bus.dm_memwrite !== 1'b1 || bus.dm_addr !== 64'd16) begin n_bad++; $display("FAIL part_c0 got stall=%0h data=%0h re=%0h we=%0h a=%0d want 1/0/0/1/16", bus.ld_stall, bus.ld_data, bus.dm_memread, bus.dm_memwrite, bus.dm_addr); end
    tick; #1;
    n_cmp++; if (bus.ld_stall !== 1'b1 || bus.dm_addr !== 64'd20) begin n_bad++; $display("FAIL part_c1 got stall=%0h a=%0d want 1/20", bus.ld_stall, bus.dm_addr); end
    tick; #1;
    n_cmp++; if (bus.ld_stall !== 1'b0 || bus.dm_memread !== 1'b1 || bus.ld_data !== 64'hD012) begin n_bad++; $display("FAIL part_release got stall=%0h re=%0h data=%0h want 0/1/d012", bus.ld_stall, bus.dm_memread, bus.ld_data); end
    store_with_load(64'd20, 64'h55);
    tick; bus.st_valid = 0; bus.ld_addr = 64'd24; #1;
    n_cmp++; if (bus.ld_stall !== 1'b0 || bus.dm_memread !== 1'b1 || bus.ld_data !== 64'hC || bus.dm_memwrite !== 1'b0) begin n_bad++; $display("FAIL part_dist4 got stall=%0h re=%0h data=%0h we=%0h want 0/1/c/0", bus.ld_stall, bus.dm_memread, bus.ld_data, bus.dm_memwrite); end
    tick; idle; #1;
    n_cmp++; if (bus.dm_memwrite !== 1'b1 || bus.dm_addr !== 64'd20 || bus.dm_wdata !== 64'h55) begin n_bad++; $display("FAIL part_tail got we=%0h a=%0d d=%0h want 1/20/55", bus.dm_memwrite, bus.dm_addr, bus.dm_wdata); end
    tick;
  endtask

  task automatic test_fence_reset;
    store_with_load(64'd40, 64'h61);
    store_with_load(64'd44, 64'h62);
    store_with_load(64'd48, 64'h63);
    for (int c = 0; c < 4; c++) begin
      tick; idle; bus.drain_req = 1; bus.st_valid = 1; bus.st_addr = 64'd52; bus.st_data = 64'h64; #1;
      n_cmp++; if (bus.st_ready !== 1'b0) begin n_bad++; $display("FAIL fence_ready_c%0d got %0h want 0", c, bus.st_ready); end
      n_cmp++; if (bus.drained !== (c == 3)) begin n_bad++; $display("FAIL fence_drained_c%0d got %0h want %0h", c, bus.drained, (c == 3)); end
    end
    n_cmp++; if (mem[40] !== 32'h61 || mem[48] !== 32'h63 || mem[52] !== 32'hD034) begin n_bad++; $display("FAIL fence_mem got %0h %0h %0h want 61 63 d034", mem[40], mem[48], mem[52]); end
    store_with_load(64'd60, 64'h71);
    bus.drain_req = 0;
    store_with_load(64'd64, 64'h72);
    tick; idle; reset = 1; #1;
    base = n_writes;
    n_cmp++; if (bus.occupancy !== 3'd0 || bus.dm_memwrite !== 1'b0 || bus.drained !== 1'b1) begin n_bad++; $display("FAIL rst_mid got occ=%0d we=%0h drained=%0h want 0/0/1", bus.occupancy, bus.dm_memwrite, bus.drained); end
    tick; reset = 0;
    tick; tick; tick; #1;
    n_cmp++; if (n_writes - base !== 0 || mem[60] !== 32'hD03C || mem[64] !== 32'hD040) begin n_bad++; $display("FAIL rst_no_write got writes=%0d m60=%0h m64=%0h want 0/d03c/d040", n_writes - base, mem[60], mem[64]); end
  endtask

  initial begin
    test_reset;
    test_drain_order;
    test_full;
    test_forward;
    test_partial;
    test_fence_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
